// File: rtl/ask_pkg.sv
// Shared ASK definitions: mode encodings, slicer states and timing defaults.
// Used by both the modulator and demodulator sides.
package ask_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_2ASK = 2'b01,
        MODE_4ASK = 2'b10,
        MODE_8ASK = 2'b11
    } ask_mode_e;

    typedef enum logic [1:0] {
        IDLE,
        CMP,
        DONE,
        SER
    } slc_state_e;

    localparam int CARRIER_PERIOD_DEF = 50;
    localparam int BIT_CYCLES_DEF     = 5000;
    localparam int ENV_FULL_DEF       = 102;

    // The mode encoding doubles as the number of bits per symbol.
    function automatic logic [1:0] bits_per_sym(input logic [1:0] mode);
        return mode;
    endfunction

endpackage

// File: rtl/ask_demodulator_if.sv
// Sample/mode inputs and symbol/bit outputs of the ASK demodulator.
// ASK_DEMOD_ENV_OUT_EN adds the env_out/env_valid bring-up signals.
interface ask_demodulator_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] sample_in;
    logic [1:0]            mixer_mode;
    logic [2:0]            sym_out;
    logic                  sym_valid;
    logic                  bit_out;
    logic                  bit_valid;
    logic                  busy;
`ifdef ASK_DEMOD_ENV_OUT_EN
    logic [DATA_WIDTH-1:0] env_out;
    logic                  env_valid;

    modport master (
        output sample_in, mixer_mode,
        input  sym_out, sym_valid, bit_out, bit_valid, busy,
        input  env_out, env_valid
    );
    modport slave (
        input  sample_in, mixer_mode,
        output sym_out, sym_valid, bit_out, bit_valid, busy,
        output env_out, env_valid
    );
`else
    modport master (
        output sample_in, mixer_mode,
        input  sym_out, sym_valid, bit_out, bit_valid, busy
    );
    modport slave (
        input  sample_in, mixer_mode,
        output sym_out, sym_valid, bit_out, bit_valid, busy
    );
`endif
endinterface

// File: rtl/ask_env_detect.sv
// Carrier envelope detector: peak hold over each carrier window,
// env registered at the last window sample and strobed one cycle later.
module ask_env_detect
    import ask_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int CARRIER_PERIOD = CARRIER_PERIOD_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic [DATA_WIDTH-1:0] sample_in,
    output logic [DATA_WIDTH-1:0] env,
    output logic                  env_valid
);
    localparam int WCW = (CARRIER_PERIOD > 2) ? $clog2(CARRIER_PERIOD) : 1;

    logic [WCW-1:0]        wc_q, wc_d;
    logic [DATA_WIDTH-1:0] pk_q, pk_d, env_q, env_d, pk_max;
    logic                  env_valid_q, env_valid_d;

    always_comb begin
        pk_max      = (sample_in > pk_q) ? sample_in : pk_q;
        wc_d        = wc_q + WCW'(1);
        pk_d        = pk_max;
        env_d       = env_q;
        env_valid_d = 1'b0;
        if (clr) begin
            wc_d = '0;
            pk_d = '0;
        end else if (wc_q == WCW'(CARRIER_PERIOD - 1)) begin
            wc_d        = '0;
            pk_d        = '0;
            env_d       = pk_max;
            env_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wc_q        <= '0;
            pk_q        <= '0;
            env_q       <= '0;
            env_valid_q <= 1'b0;
        end else begin
            wc_q        <= wc_d;
            pk_q        <= pk_d;
            env_q       <= env_d;
            env_valid_q <= env_valid_d;
        end
    end

    assign env       = env_q;
    assign env_valid = env_valid_q;

endmodule

// File: rtl/ask_demodulator.sv
// ASK demodulator: per-symbol envelope average, linear slicer, MSB-first serialiser.
// ASK_DEMOD_ENV_OUT_EN exposes the per-window envelope for calibration.
module ask_demodulator
    import ask_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int CARRIER_PERIOD = CARRIER_PERIOD_DEF,
    parameter int BIT_CYCLES     = BIT_CYCLES_DEF,
    parameter int ENV_FULL       = ENV_FULL_DEF
) (
    input  logic clk,
    input  logic rst,
    ask_demodulator_if.slave bus
);
    localparam int SCW = $clog2(3 * BIT_CYCLES + 1);

    logic [1:0]            mode, mode_q, n;
    logic                  off, chg, clr, sym_end;
    logic [SCW-1:0]        sc_q, sc_d, last_sc;
    logic [DATA_WIDTH-1:0] env, step;
    logic                  env_valid;
    logic [16:0]           acc_sum;
    logic [15:0]           acc_q, acc_d, acc_add, acc_s_q, acc_s_d;
    logic [8:0]            nw_q, nw_d, nw_add, nw_s_q, nw_s_d;
    logic [2:0]            k_q, k_d, k_max, sym_q, sym_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [23:0]           thr_prod, thr;
    logic                  cmp_done;
    logic                  sym_valid_q, sym_valid_d, bit_q, bit_d;
    logic                  bit_valid_q, bit_valid_d, busy_q, busy_d;
    slc_state_e            state_q, state_d;

    assign mode    = bus.mixer_mode;
    assign n       = bits_per_sym(mode);
    assign off     = (mode == MODE_OFF);
    assign chg     = (mode != mode_q);
    assign clr     = off || chg;
    assign sym_end = !clr && (sc_q == last_sc);

    ask_env_detect #(
        .DATA_WIDTH     (DATA_WIDTH),
        .CARRIER_PERIOD (CARRIER_PERIOD)
    ) u_env (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .sample_in (bus.sample_in),
        .env       (env),
        .env_valid (env_valid)
    );

    always_comb begin
        last_sc = '0;
        step    = '0;
        k_max   = 3'd0;
        case (mode)
            MODE_2ASK: begin
                last_sc = SCW'(BIT_CYCLES);
                step    = DATA_WIDTH'(ENV_FULL);
                k_max   = 3'd1;
            end
            MODE_4ASK: begin
                last_sc = SCW'(2 * BIT_CYCLES);
                step    = DATA_WIDTH'(ENV_FULL >> 1);
                k_max   = 3'd3;
            end
            MODE_8ASK: begin
                last_sc = SCW'(3 * BIT_CYCLES);
                step    = DATA_WIDTH'(ENV_FULL >> 2);
                k_max   = 3'd7;
            end
            default: ;
        endcase
    end

    // The window completing on the symbol-end cycle belongs to that symbol.
    always_comb begin
        acc_sum = {1'b0, acc_q} + (env_valid ? 17'(env) : 17'd0);
        acc_add = acc_sum[16] ? 16'hFFFF : acc_sum[15:0];
        nw_add  = nw_q + (env_valid ? 9'd1 : 9'd0);
        sc_d    = (clr || sym_end) ? '0 : sc_q + SCW'(1);
        acc_d   = (clr || sym_end) ? '0 : acc_add;
        nw_d    = (clr || sym_end) ? '0 : nw_add;
    end

    always_comb begin
        thr_prod = 24'({k_q, 1'b1}) * 24'(step) * 24'(nw_s_q);
        thr      = thr_prod >> 1;
        cmp_done = (24'(acc_s_q) < thr) || (k_q == k_max);
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        cnt_d       = cnt_q;
        sym_d       = sym_q;
        sym_valid_d = 1'b0;
        bit_d       = bit_q;
        bit_valid_d = 1'b0;
        acc_s_d     = acc_s_q;
        nw_s_d      = nw_s_q;
        if (clr) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (sym_end) begin
                    state_d = CMP;
                    k_d     = 3'd0;
                    acc_s_d = acc_add;
                    nw_s_d  = nw_add;
                end
                CMP: if (cmp_done) begin
                    state_d     = DONE;
                    sym_d       = k_q;
                    sym_valid_d = 1'b1;
                end else begin
                    k_d = k_q + 3'd1;
                end
                DONE: begin
                    state_d     = SER;
                    bit_d       = sym_q[n - 2'd1];
                    bit_valid_d = 1'b1;
                    cnt_d       = n - 2'd1;
                end
                SER: if (cnt_q == 2'd0) begin
                    state_d = IDLE;
                end else begin
                    bit_d       = sym_q[cnt_q - 2'd1];
                    bit_valid_d = 1'b1;
                    cnt_d       = cnt_q - 2'd1;
                end
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    // mode_q tracks the input during reset so releasing reset is not a mode change.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q      <= bus.mixer_mode;
            sc_q        <= '0;
            acc_q       <= '0;
            nw_q        <= '0;
            acc_s_q     <= '0;
            nw_s_q      <= '0;
            k_q         <= '0;
            cnt_q       <= '0;
            sym_q       <= '0;
            sym_valid_q <= 1'b0;
            bit_q       <= 1'b0;
            bit_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
        end else begin
            mode_q      <= mode;
            sc_q        <= sc_d;
            acc_q       <= acc_d;
            nw_q        <= nw_d;
            acc_s_q     <= acc_s_d;
            nw_s_q      <= nw_s_d;
            k_q         <= k_d;
            cnt_q       <= cnt_d;
            sym_q       <= sym_d;
            sym_valid_q <= sym_valid_d;
            bit_q       <= bit_d;
            bit_valid_q <= bit_valid_d;
            busy_q      <= busy_d;
            state_q     <= state_d;
        end
    end

    assign bus.sym_out   = sym_q;
    assign bus.sym_valid = sym_valid_q;
    assign bus.bit_out   = bit_q;
    assign bus.bit_valid = bit_valid_q;
    assign bus.busy      = busy_q;
`ifdef ASK_DEMOD_ENV_OUT_EN
    assign bus.env_out   = env;
    assign bus.env_valid = env_valid;
`endif

endmodule

// File: tb/tb_ask_demodulator.sv
// Scoreboard bench for ask_demodulator: directed symbol sequences per mode,
// expected symbols/bits queued with their strobe cycle and checked by a monitor.
module tb_ask_demodulator;
    import ask_pkg::*;

    typedef struct {
        int v;
        int c;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ask_demodulator_if #(.DATA_WIDTH(8)) bus ();

    ask_demodulator #(
        .DATA_WIDTH     (8),
        .CARRIER_PERIOD (50),
        .BIT_CYCLES     (5000),
        .ENV_FULL       (102)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   cyc     = 0;
    int   checks  = 0;
    int   passed  = 0;
    int   amp     = 0;
    bit   in_off  = 1'b0;
    int   off_hit = 0;
    exp_t exp_sym[$];
    exp_t exp_bit[$];

    function automatic logic [7:0] wave(input int a, input int c);
        real ph;
        ph = 2.0 * 3.14159265358979 * real'(c % 50) / 50.0;
        return 8'($rtoi(real'(a) * (1.0 + $cos(ph)) / 2.0 + 0.5));
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        bus.sample_in = wave(amp, cyc);
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic set_amp(input int a);
        amp = a;
        bus.sample_in = wave(amp, cyc);
    endtask

    task automatic push_sym(input int v, input int c);
        exp_t e;
        e.v = v;
        e.c = c;
        exp_sym.push_back(e);
    endtask

    task automatic push_bit(input int v, input int c);
        exp_t e;
        e.v = v;
        e.c = c;
        exp_bit.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.sym_valid === 1'b1) begin
            if (exp_sym.size() == 0) begin
                checks++;
                $display("FAIL sym_unexpected: sym_valid at cycle %0d, none expected", cyc);
            end else begin
                e = exp_sym.pop_front();
                chk("sym_value", int'(bus.sym_out), e.v);
                chk("sym_cycle", cyc, e.c);
            end
        end
        if (bus.bit_valid === 1'b1) begin
            if (exp_bit.size() == 0) begin
                checks++;
                $display("FAIL bit_unexpected: bit_valid at cycle %0d, none expected", cyc);
            end else begin
                e = exp_bit.pop_front();
                chk("bit_value", int'(bus.bit_out), e.v);
                chk("bit_cycle", cyc, e.c);
            end
        end
        if (in_off && (bus.busy !== 1'b0)) off_hit++;
    end

    initial begin
        int r, t, e1, e2, t2;
        int amps[4];
        amps[0] = 0;
        amps[1] = 51;
        amps[2] = 102;
        amps[3] = 153;

        bus.mixer_mode = MODE_2ASK;
        bus.sample_in  = '0;
        set_amp(102);
        repeat (3) tick();
        chk("reset_outputs", int'({bus.sym_out, bus.sym_valid, bus.bit_out,
                                   bus.bit_valid, bus.busy}), 0);

        // 2ASK, peak 102: symbol end at sc==5000, sym 1 three cycles later
        rst = 1'b0;
        r = cyc;
        push_sym(1, r + 5000 + 3);
        push_bit(1, r + 5000 + 4);

        // switch to 8ASK at sc==2500 of the second 2ASK symbol
        t = r + 5001 + 2500;
        run_to(t);
        bus.mixer_mode = MODE_8ASK;
        set_amp(255);
        e1 = t + 15001;
        push_sym(7, e1 + 9);
        push_bit(1, e1 + 10);
        push_bit(1, e1 + 11);
        push_bit(1, e1 + 12);

        // next 8ASK symbol at peak 127 slices to 5 (101)
        run_to(e1 + 1);
        set_amp(127);
        e2 = e1 + 15001;
        push_sym(5, e2 + 7);
        push_bit(1, e2 + 8);

        run_to(e1 + 12);
        chk("busy_in_ser", int'(bus.busy), 1);
        run_to(e1 + 13);
        chk("busy_released", int'(bus.busy), 0);

        // reset after the first serialised bit
        run_to(e2 + 8);
        rst = 1'b1;
        tick();
        chk("rst_mid_ser_outputs", int'({bus.sym_out, bus.sym_valid, bus.bit_out,
                                         bus.bit_valid, bus.busy}), 0);
        chk("rst_bit_valid_drop", int'(bus.bit_valid), 0);

        // mode off with full-scale input
        bus.mixer_mode = MODE_OFF;
        set_amp(255);
        repeat (2) tick();
        rst = 1'b0;
        in_off = 1'b1;
        repeat (6000) tick();
        in_off = 1'b0;
        chk("off_busy_cycles", off_hit, 0);

        // 4ASK, peaks 0/51/102/153
        t2 = cyc;
        bus.mixer_mode = MODE_4ASK;
        set_amp(amps[0]);
        for (int j = 0; j < 4; j++) begin
            int ej;
            ej = t2 + (j + 1) * 10001;
            push_sym(j, ej + j + 2);
            push_bit((j >> 1) & 1, ej + j + 3);
            push_bit(j & 1, ej + j + 4);
        end
        for (int j = 0; j < 4; j++) begin
            run_to(t2 + 1 + j * 10001);
            set_amp(amps[j]);
        end
        run_to(t2 + 4 * 10001 + 12);

        chk("sym_queue_left", exp_sym.size(), 0);
        chk("bit_queue_left", exp_bit.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
